cpu_sequencer: RTL and testbench

//  Fetch/execute/writeback controller directly upstream and downstream of the 8-bit ALU.
//  - Accepts one instruction byte per handshake.
//  - Reads two operands from a 4x8 register file and drives the ALU's opcode/addrs/data inputs.
//  - Writes the ALU result back and latches the carry/borrow flags.
//  - Resolves conditional branches against those flags and owns the program counter.
//  - Owns the toggle output pin.

---
 rtl/cpu_sequencer_pkg.sv | 28 ++
 rtl/cpu_sequencer_if.sv | 32 +++
 rtl/cpu_sequencer_regfile_4x8.sv | 26 ++
 rtl/cpu_sequencer.sv | 104 ++++++++++
 tb/tb_cpu_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the fetch/execute/writeback sequencer: opcodes, FSM
// state encoding and instruction-field helpers.
package cpu_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2
  } seqState_t;

  function automatic logic [1:0] irOpcode(input logic [7:0] ir);
    return ir[7:6];
  endfunction

  function automatic logic [1:0] irRd(input logic [7:0] ir);
    return ir[5:4];
  endfunction

  function automatic logic [1:0] irRs(input logic [7:0] ir);
    return ir[3:2];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction handshake, ALU-side bus, program counter and toggle pin of the sequencer.
// Handshake: a byte on instr is consumed on a rising edge where instr_valid && instr_ready.
interface cpu_sequencer_if #(parameter int PC_W = 8);
  logic [7:0]      instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [1:0]      alu_opcode;
  logic [3:0]      alu_addrs;
  logic [7:0]      alu_din0;
  logic [7:0]      alu_din1;
  logic [7:0]      alu_dout;
  logic            alu_carry;
  logic            alu_borrow;
  logic            alu_bcf;
  logic            alu_bbf;
  logic            alu_buc;
  logic            alu_toggle;
  logic            toggle_out;

  modport master (
    input  instr, instr_valid, alu_dout, alu_carry, alu_borrow,
           alu_bcf, alu_bbf, alu_buc, alu_toggle,
    output instr_ready, pc, alu_opcode, alu_addrs, alu_din0, alu_din1, toggle_out
  );

  modport slave (
    output instr, instr_valid, alu_dout, alu_carry, alu_borrow,
           alu_bcf, alu_bbf, alu_buc, alu_toggle,
    input  instr_ready, pc, alu_opcode, alu_addrs, alu_din0, alu_din1, toggle_out
  );
endinterface

// File: rtl/cpu_sequencer_regfile_4x8.sv
// 4x8 register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear.
module regfile_4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rdAddr0,
  input  logic [1:0] rdAddr1,
  output logic [7:0] rdData0,
  output logic [7:0] rdData1,
  input  logic       wrEn,
  input  logic [1:0] wrAddr,
  input  logic [7:0] wrData
);
  logic [7:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdData0 = regs[rdAddr0];
  assign rdData1 = regs[rdAddr1];
endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute/writeback controller around an external 8-bit ALU: owns the IR,
// register file, carry/borrow flags, program counter and toggle pin.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_sequencer_if.master bus,
  output seqState_t      dbgState
);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  seqState_t       state, stateNext;
  logic            loadIr, execEn, wbEn;
  logic [7:0]      ir, res;
  logic            cflag, bflag, take, isbr, toggleOut;
  logic [PC_W-1:0] pc, resPc;
  logic [7:0]      rdData0, rdData1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_FETCH: if (bus.instr_valid) stateNext = ST_EXEC;
      ST_EXEC:  stateNext = ST_WB;
      ST_WB:    stateNext = ST_FETCH;
      default:  stateNext = ST_FETCH;
    endcase
  end

  always_comb begin
    loadIr = 1'b0;
    execEn = 1'b0;
    wbEn   = 1'b0;
    case (state)
      ST_FETCH: loadIr = bus.instr_valid;
      ST_EXEC:  execEn = 1'b1;
      ST_WB:    wbEn   = 1'b1;
      default:  ;
    endcase
  end

  // Branch targets come from the ALU result, widened or narrowed to the PC width.
  generate
    if (PC_W > 8) begin : gResExt
      assign resPc = {{(PC_W-8){1'b0}}, res};
    end else begin : gResTrunc
      assign resPc = res[PC_W-1:0];
    end
  endgenerate

  // take is formed from the flags as they stood before this instruction updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= 8'h00;
      res       <= 8'h00;
      cflag     <= 1'b0;
      bflag     <= 1'b0;
      take      <= 1'b0;
      isbr      <= 1'b0;
      toggleOut <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      if (loadIr) ir <= bus.instr;
      if (execEn) begin
        res  <= bus.alu_dout;
        take <= bus.alu_buc | (bus.alu_bcf & cflag) | (bus.alu_bbf & bflag);
        isbr <= bus.alu_buc | bus.alu_bcf | bus.alu_bbf;
        if (irOpcode(ir) == OP_ADD) cflag <= bus.alu_carry;
        if (irOpcode(ir) == OP_SUB) bflag <= bus.alu_borrow;
        if (bus.alu_toggle) toggleOut <= ~toggleOut;
      end
      if (wbEn) pc <= take ? resPc : pc + PC_ONE;
    end
  end

  regfile_4x8 uRegfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdAddr0 (irRd(ir)),
    .rdAddr1 (irRs(ir)),
    .rdData0 (rdData0),
    .rdData1 (rdData1),
    .wrEn    (wbEn & ~isbr),
    .wrAddr  (irRd(ir)),
    .wrData  (res)
  );

  assign bus.instr_ready = (state == ST_FETCH);
  assign bus.pc          = pc;
  assign bus.alu_opcode  = irOpcode(ir);
  assign bus.alu_addrs   = ir[5:2];
  assign bus.alu_din0    = rdData0;
  assign bus.alu_din1    = rdData1;
  assign bus.toggle_out  = toggleOut;
  assign dbgState        = state;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: the bench plays the ALU and compares the
// sequencer against an instruction-level reference model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic      clk;
  logic      rst_n;
  seqState_t dbgState;
  int        checkCnt = 0;
  int        failCnt  = 0;

  cpu_sequencer_if #(.PC_W(8)) bus();

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .dbgState (dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural state after each completed instruction.
  logic [7:0] mR [4];
  logic       mC, mB, mTog;
  logic [7:0] mPc;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mR[i] = 8'h00;
    mC = 1'b0; mB = 1'b0; mTog = 1'b0; mPc = 8'h00;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkEq("ready_fetch", 32'(bus.instr_ready), 32'd1);
  endtask

  // One full instruction; called and returning just after a falling edge.
  task automatic runInstr(input logic [7:0] ins, input logic [7:0] dout,
                          input logic cy, input logic bw, input logic bcf,
                          input logic bbf, input logic buc, input logic tog,
                          input bit junk);
    logic [1:0] op, rd, rs;
    logic       take, isbr;
    op = ins[7:6]; rd = ins[5:4]; rs = ins[3:2];
    waitReady();
    bus.instr = ins; bus.instr_valid = 1'b1;
    bus.alu_dout = dout; bus.alu_carry = cy; bus.alu_borrow = bw;
    bus.alu_bcf = bcf; bus.alu_bbf = bbf; bus.alu_buc = buc; bus.alu_toggle = tog;
    @(negedge clk);
    bus.instr_valid = junk;
    bus.instr = junk ? 8'($urandom) : 8'h00;
    checkEq("ready_exec", 32'(bus.instr_ready), 32'd0);
    checkEq("alu_opcode", 32'(bus.alu_opcode), 32'(op));
    checkEq("alu_addrs", 32'(bus.alu_addrs), 32'(ins[5:2]));
    checkEq("alu_din0", 32'(bus.alu_din0), 32'(mR[rd]));
    checkEq("alu_din1", 32'(bus.alu_din1), 32'(mR[rs]));
    @(negedge clk);
    if (junk) bus.instr = 8'($urandom);
    checkEq("ready_wb", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    take = buc | (bcf & mC) | (bbf & mB);
    isbr = buc | bcf | bbf;
    if (op == OP_ADD) mC = cy;
    if (op == OP_SUB) mB = bw;
    if (tog) mTog = ~mTog;
    if (!isbr) mR[rd] = dout;
    mPc = take ? dout : mPc + 8'd1;
    checkEq("ready_back", 32'(bus.instr_ready), 32'd1);
    checkEq("pc", 32'(bus.pc), 32'(mPc));
    checkEq("toggle_out", 32'(bus.toggle_out), 32'(mTog));
  endtask

  // Bench acting as the ALU: result and flags from the model's operand values.
  task automatic aluRun(input logic [7:0] ins, input logic bcf, input logic bbf,
                        input logic buc, input logic tog, input bit junk);
    logic [7:0] a, b, d;
    logic [8:0] sum;
    logic       cy, bw;
    a = mR[ins[5:4]]; b = mR[ins[3:2]];
    sum = {1'b0, a} + {1'b0, b};
    cy = 1'($urandom); bw = 1'($urandom);
    case (ins[7:6])
      OP_ADD: begin d = sum[7:0]; cy = sum[8]; end
      OP_SUB: begin d = a - b; bw = (a < b); end
      OP_XOR: d = a ^ b;
      default: d = b;
    endcase
    runInstr(ins, d, cy, bw, bcf, bbf, buc, tog, junk);
  endtask

  task automatic loadReg(input logic [1:0] rd, input logic [7:0] val);
    runInstr({OP_MOV, rd, rd, 2'b00}, val, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetMid(input logic [7:0] ins);
    waitReady();
    bus.instr = ins; bus.instr_valid = 1'b1; bus.alu_dout = 8'hA5; bus.alu_toggle = 1'b1;
    bus.alu_buc = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checkEq("mid_in_exec", 32'(dbgState), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    checkEq("mid_async_ready", 32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.alu_toggle = 1'b0; bus.alu_buc = 1'b0;
    modelReset();
    checkEq("mid_ready", 32'(bus.instr_ready), 32'd1);
    checkEq("mid_pc", 32'(bus.pc), 32'd0);
    checkEq("mid_toggle", 32'(bus.toggle_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.instr = 8'h00; bus.instr_valid = 1'b0; bus.alu_dout = 8'h00;
    bus.alu_carry = 1'b0; bus.alu_borrow = 1'b0; bus.alu_bcf = 1'b0;
    bus.alu_bbf = 1'b0; bus.alu_buc = 1'b0; bus.alu_toggle = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("rst_ready", 32'(bus.instr_ready), 32'd1);
    checkEq("rst_state", 32'(dbgState), 32'(ST_FETCH));
    checkEq("rst_pc", 32'(bus.pc), 32'd0);
    checkEq("rst_toggle", 32'(bus.toggle_out), 32'd0);
    // ADD with no carry
    loadReg(2'd1, 8'd5);
    loadReg(2'd2, 8'd3);
    aluRun({OP_ADD, 2'd1, 2'd2, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ADD with carry, then taken branch-if-carry to R[rs]
    loadReg(2'd0, 8'hF0);
    loadReg(2'd1, 8'h20);
    aluRun({OP_ADD, 2'd0, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    loadReg(2'd2, 8'h40);
    aluRun({OP_MOV, 2'd3, 2'd2, 2'b00}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    aluRun({OP_XOR, 2'd3, 2'd2, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // SUB with borrow, clear carry, then untaken branch-if-carry
    loadReg(2'd0, 8'h02);
    loadReg(2'd1, 8'h05);
    aluRun({OP_SUB, 2'd0, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    aluRun({OP_ADD, 2'd2, 2'd2, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    aluRun({OP_MOV, 2'd3, 2'd0, 2'b00}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    aluRun({OP_MOV, 2'd3, 2'd2, 2'b00}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // PC wrap at 0xFF and toggle twice
    loadReg(2'd1, 8'hFF);
    aluRun({OP_MOV, 2'd0, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkEq("pc_at_ff", 32'(bus.pc), 32'hFF);
    aluRun({OP_XOR, 2'd2, 2'd3, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkEq("pc_wrapped", 32'(bus.pc), 32'h00);
    aluRun({OP_XOR, 2'd3, 2'd2, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Reset during EXEC, then confirm the register file is clear
    resetMid({OP_MOV, 2'd0, 2'd1, 2'b00});
    aluRun({OP_ADD, 2'd0, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    aluRun({OP_XOR, 2'd2, 2'd3, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // instr_valid held high with changing bytes across two instructions
    loadReg(2'd1, 8'h11);
    aluRun({OP_ADD, 2'd1, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    aluRun({OP_SUB, 2'd2, 2'd1, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.instr_valid = 1'b0;
    aluRun({OP_XOR, 2'd1, 2'd2, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      aluRun(8'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             bit'($urandom_range(0, 1)));
    end
    bus.instr_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
